pio_led_streamer: RTL and testbench
===================================

Name: pio_led_streamer

Overview:
Host-side sequencer for one PIO instance, driving WS2812-style LED strings on up to four state machines. After reset it loads the PIO instruction memory from an external program ROM, then applies machine configuration words from an external config ROM. It then repeatedly streams a frame of 24-bit pixels from an external pixel RAM into the TX FIFOs, round-robin across channels, honouring per-channel FIFO-full back-pressure. Each frame is followed by a programmable latch gap.

Parameters:
NUM_CH, 1, number of active state machines/LED strings (1..4)
NUM_PIX, 16, pixels per channel
PROG_LEN, 32, instructions to load (1..32)
CONF_LEN, 7, config words to apply (1..32)
GAP_CYCLES, 1250, idle cycles after the last push of a frame (latch/reset time)
PIX_AW, 8, pixel RAM address width; NUM_CH*NUM_PIX <= 2^PIX_AW

Ports:
clk_25mhz  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  run frames while high
prog_addr  out  5  program ROM address (combinational read)
prog_data  in  16  instruction word
conf_addr  out  5  config ROM address (combinational read)
conf_data  in  38  [37:36] mindex, [35:32] action, [31:0] data
pix_addr  out  PIX_AW  pixel RAM address (combinational read)
pix_data  in  24  GRB pixel
action  out  4  PIO action
index  out  5  PIO instruction index
mindex  out  2  PIO machine index
din  out  32  PIO data
full  in  4  PIO TX FIFO full per machine
busy  out  1  high when state != IDLE
loaded  out  1  sticky; high once configuration is complete
frame_done  out  1  one-cycle pulse at end of gap
frame_cnt  out  16  frames completed, wraps
stall_cnt  out  16  cycles blocked on full, saturates at 16'hFFFF

Behaviour:
- Reset (synchronous, active-high, clock clk_25mhz): all outputs and counters 0; state LOAD with k=0. Reset asserted in any state aborts it and restarts from LOAD, including reload of the program.
- All PIO outputs (action, index, mindex, din) are registered.
- LOAD:
  - Cycle k drives prog_addr=k. On the next cycle, outputs are action=1, index=k, mindex=0, din={16'h0, prog_data}.
  - After k=PROG_LEN-1, go to CONFIG with j=0.
- CONFIG:
  - Cycle j drives conf_addr=j. On the next cycle, outputs are action=conf_data[35:32], mindex=conf_data[37:36], din=conf_data[31:0].
  - After j=CONF_LEN-1, one cycle with action=0, mindex=0. Then loaded<=1 and go to IDLE.
- IDLE: action=0. If enable, go to FRAME with p=0.
- FRAME: linear pointer p, 0..NUM_CH*NUM_PIX-1. pix_addr=p, channel ch=p mod NUM_CH. Each push takes two phases:
  - Phase A: if full[ch]=0, output action=4, mindex=ch, din={pix_data, 8'h00}. If full[ch]=1, no push, stall_cnt increments (saturating), remain in phase A on the same p. Other channels are never skipped ahead.
  - Phase B: action=0, p<=p+1. After the last p, go to GAP.
  - Maximum push rate is one per 2 cycles.
- GAP:
  - Count GAP_CYCLES cycles with action=0. gap_cnt starts at 0 on the cycle after the last phase B.
  - On the final count: frame_done=1 for one cycle and frame_cnt<=frame_cnt+1.
  - Next state: FRAME with p=0 if enable, else IDLE.
- enable is sampled only in IDLE and at the end of GAP. Deassertion mid-frame completes the frame and its gap.
- full bits for machines >= NUM_CH are ignored.
- din bits [7:0] are always 0 during pushes.

Test Plan:
- Reset then release, PROG_LEN=32, ROM[k]=16'hA000+k: cycles 1..32 after release show action=1, index=0..31, din=0000A000..0000A01F. Then CONFIG begins.
- CONF_LEN=7 with distinct words, including mindex=2, action=5: seven consecutive cycles reproduce each word exactly. Then action=0, loaded=1, busy=0 while enable=0.
- NUM_CH=2, NUM_PIX=3, full=0, enable=1, pix_data=addr-derived: six pushes on alternate cycles. mindex sequence 0,1,0,1,0,1 and din={pix[p],8'h00}. GAP_CYCLES=10: frame_done exactly 10 cycles after last phase B, frame_cnt=1.
- full[1] held high 5 cycles when p=1 is due: stall_cnt=5, no action=4 during that time (channel 0 is not served), then the push to mindex=1 with pixel 1.
- enable dropped during the 2nd frame: that frame and its gap complete, frame_cnt=2, then IDLE with busy=0 and no further pushes.
- reset pulsed mid-FRAME: outputs are 0 the next cycle, loaded=0, and the program load restarts at index 0.

Source files
------------

// File: rtl/pio_led_streamer.sv
// pio_led_streamer: host-side sequencer for one PIO block.
// Loads the instruction memory from a program ROM, then applies configuration
// words from a config ROM. While enabled, it streams frames of 24-bit GRB pixels
// into the TX FIFOs round-robin across channels, and puts a latch gap after each
// frame.
//
// Handshake: a push is offered only when full[ch] is low. A push is presented
// as action=4 for exactly one cycle. A low full[ch] at the clock edge that ends
// phase A commits that push. A high full[ch] holds the pointer in place, and the
// bench can observe the hold on stall_cnt.
module pio_led_streamer #(
   parameter int NUM_CH     = 1,
   parameter int NUM_PIX    = 16,
   parameter int PROG_LEN   = 32,
   parameter int CONF_LEN   = 7,
   parameter int GAP_CYCLES = 1250,
   parameter int PIX_AW     = 8
) (
   input  logic              clk_25mhz,
   input  logic              reset,
   input  logic              enable,
   output logic [4:0]        prog_addr,
   input  logic [15:0]       prog_data,
   output logic [4:0]        conf_addr,
   input  logic [37:0]       conf_data,
   output logic [PIX_AW-1:0] pix_addr,
   input  logic [23:0]       pix_data,
   output logic [3:0]        action,
   output logic [4:0]        index,
   output logic [1:0]        mindex,
   output logic [31:0]       din,
   input  logic [3:0]        full,
   output logic              busy,
   output logic              loaded,
   output logic              frame_done,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       stall_cnt,
   output logic [2:0]        dbg_state
);

   localparam int TOTAL = NUM_CH * NUM_PIX;
   localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_LOAD     = 3'd0,
      S_CONFIG   = 3'd1,
      S_CONF_END = 3'd2,
      S_IDLE     = 3'd3,
      S_FRAME_A  = 3'd4,
      S_FRAME_B  = 3'd5,
      S_GAP      = 3'd6
   } state_t;

   state_t            r_state, w_state;
   logic [4:0]        r_k, w_k;
   logic [4:0]        r_j, w_j;
   logic [PIX_AW-1:0] r_p, w_p;
   logic [1:0]        r_ch, w_ch;
   logic [GW-1:0]     r_gap, w_gap;
   logic [3:0]        r_action, w_action;
   logic [4:0]        r_index, w_index;
   logic [1:0]        r_mindex, w_mindex;
   logic [31:0]       r_din, w_din;
   logic              r_busy, w_busy;
   logic              r_loaded, w_loaded;
   logic [15:0]       r_frame_cnt, w_frame_cnt;
   logic [15:0]       r_stall_cnt, w_stall_cnt;
   logic              w_gap_last;

   assign w_gap_last = (r_gap == GW'(GAP_CYCLES - 1));

   assign prog_addr  = r_k;
   assign conf_addr  = r_j;
   assign pix_addr   = r_p;
   assign action     = r_action;
   assign index      = r_index;
   assign mindex     = r_mindex;
   assign din        = r_din;
   assign busy       = r_busy;
   assign loaded     = r_loaded;
   assign frame_cnt  = r_frame_cnt;
   assign stall_cnt  = r_stall_cnt;
   assign frame_done = (r_state == S_GAP) && w_gap_last;
   assign dbg_state  = r_state;

   // Register state, counters and all PIO-facing outputs; reset restarts from program load.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         r_state     <= S_LOAD;
         r_k         <= '0;
         r_j         <= '0;
         r_p         <= '0;
         r_ch        <= '0;
         r_gap       <= '0;
         r_action    <= '0;
         r_index     <= '0;
         r_mindex    <= '0;
         r_din       <= '0;
         r_busy      <= 1'b0;
         r_loaded    <= 1'b0;
         r_frame_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state;
         r_k         <= w_k;
         r_j         <= w_j;
         r_p         <= w_p;
         r_ch        <= w_ch;
         r_gap       <= w_gap;
         r_action    <= w_action;
         r_index     <= w_index;
         r_mindex    <= w_mindex;
         r_din       <= w_din;
         r_busy      <= w_busy;
         r_loaded    <= w_loaded;
         r_frame_cnt <= w_frame_cnt;
         r_stall_cnt <= w_stall_cnt;
      end
   end

   // Next-state and next-output decode; PIO outputs default to a no-op each cycle.
   always_comb begin
      w_state     = r_state;
      w_k         = r_k;
      w_j         = r_j;
      w_p         = r_p;
      w_ch        = r_ch;
      w_gap       = r_gap;
      w_action    = 4'd0;
      w_index     = 5'd0;
      w_mindex    = 2'd0;
      w_din       = 32'd0;
      w_loaded    = r_loaded;
      w_frame_cnt = r_frame_cnt;
      w_stall_cnt = r_stall_cnt;

      case (r_state)
         S_LOAD: begin
            w_action = 4'd1;
            w_index  = r_k;
            w_din    = {16'h0000, prog_data};
            if (r_k == 5'(PROG_LEN - 1)) begin
               w_state = S_CONFIG;
               w_j     = 5'd0;
            end else begin
               w_k = r_k + 5'd1;
            end
         end
         S_CONFIG: begin
            w_action = conf_data[35:32];
            w_mindex = conf_data[37:36];
            w_din    = conf_data[31:0];
            if (r_j == 5'(CONF_LEN - 1)) begin
               w_state = S_CONF_END;
            end else begin
               w_j = r_j + 5'd1;
            end
         end
         S_CONF_END: begin
            w_loaded = 1'b1;
            w_state  = S_IDLE;
         end
         S_IDLE: begin
            if (enable) begin
               w_state = S_FRAME_A;
               w_p     = '0;
               w_ch    = 2'd0;
            end
         end
         S_FRAME_A: begin
            if (!full[r_ch]) begin
               w_action = 4'd4;
               w_mindex = r_ch;
               w_din    = {pix_data, 8'h00};
               w_state  = S_FRAME_B;
            end else if (r_stall_cnt != 16'hFFFF) begin
               w_stall_cnt = r_stall_cnt + 16'd1;
            end
         end
         S_FRAME_B: begin
            if (r_p == PIX_AW'(TOTAL - 1)) begin
               w_state = S_GAP;
               w_gap   = '0;
            end else begin
               w_p     = r_p + PIX_AW'(1);
               w_ch    = (r_ch == 2'(NUM_CH - 1)) ? 2'd0 : r_ch + 2'd1;
               w_state = S_FRAME_A;
            end
         end
         S_GAP: begin
            if (w_gap_last) begin
               w_frame_cnt = r_frame_cnt + 16'd1;
               w_p         = '0;
               w_ch        = 2'd0;
               w_state     = enable ? S_FRAME_A : S_IDLE;
            end else begin
               w_gap = r_gap + GW'(1);
            end
         end
         default: begin
            w_state = S_LOAD;
            w_k     = 5'd0;
         end
      endcase

      w_busy = (w_state != S_IDLE);
   end

endmodule

// File: tb/tb_pio_led_streamer.sv
// tb_pio_led_streamer: directed bench for pio_led_streamer. It uses two
// channels, three pixels per channel and a ten-cycle gap.
module tb_pio_led_streamer;

   localparam int NUM_CH     = 2;
   localparam int NUM_PIX    = 3;
   localparam int PROG_LEN   = 32;
   localparam int CONF_LEN   = 7;
   localparam int GAP_CYCLES = 10;
   localparam int PIX_AW     = 8;
   localparam logic [2:0] ST_FRAME_A = 3'd4;

   logic              clk_25mhz = 1'b0;
   logic              reset;
   logic              enable;
   logic [4:0]        prog_addr;
   logic [15:0]       prog_data;
   logic [4:0]        conf_addr;
   logic [37:0]       conf_data;
   logic [PIX_AW-1:0] pix_addr;
   logic [23:0]       pix_data;
   logic [3:0]        action;
   logic [4:0]        index;
   logic [1:0]        mindex;
   logic [31:0]       din;
   logic [3:0]        full;
   logic              busy;
   logic              loaded;
   logic              frame_done;
   logic [15:0]       frame_cnt;
   logic [15:0]       stall_cnt;
   logic [2:0]        dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   logic [37:0] conf_rom [0:CONF_LEN-1];
   logic [33:0] exp_q [$];

   // Clock and reset block
   always #20 clk_25mhz = ~clk_25mhz;

   pio_led_streamer #(
      .NUM_CH(NUM_CH), .NUM_PIX(NUM_PIX), .PROG_LEN(PROG_LEN),
      .CONF_LEN(CONF_LEN), .GAP_CYCLES(GAP_CYCLES), .PIX_AW(PIX_AW)
   ) dut (
      .clk_25mhz(clk_25mhz), .reset(reset), .enable(enable),
      .prog_addr(prog_addr), .prog_data(prog_data),
      .conf_addr(conf_addr), .conf_data(conf_data),
      .pix_addr(pix_addr), .pix_data(pix_data),
      .action(action), .index(index), .mindex(mindex), .din(din),
      .full(full), .busy(busy), .loaded(loaded), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
   );

   // External memory models with combinational reads
   assign prog_data = 16'hA000 + {11'd0, prog_addr};
   assign conf_data = (conf_addr < 5'(CONF_LEN)) ? conf_rom[conf_addr[2:0]] : 38'd0;
   assign pix_data  = {pix_addr + 8'h11, pix_addr + 8'h22, pix_addr + 8'h33};

   function automatic logic [31:0] pix_word(input int p);
      logic [7:0] a;
      a = 8'(p);
      return {a + 8'h11, a + 8'h22, a + 8'h33, 8'h00};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_25mhz);
      #1;
   endtask

   // Runs one frame plus its gap. It can optionally stall channel 1 for five
   // cycles when p=1 is due, and it can drop enable partway through the frame.
   task automatic run_frame(input bit do_stall, input bit drop_en, input int exp_frames);
      int cyc = 0;
      int last_push = -100;
      int pushes = 0;
      int stall_left = 0;
      int blocked_push = 0;
      bit stalled = 1'b0;
      bit got_done = 1'b0;
      logic [33:0] e;
      for (int p = 0; p < NUM_CH * NUM_PIX; p++)
         exp_q.push_back({2'(p % NUM_CH), pix_word(p)});
      while (cyc < 200 && !got_done) begin
         tick();
         cyc++;
         if (drop_en && cyc == 3) enable = 1'b0;
         if (stall_left > 0) begin
            if (action == 4'd4) blocked_push++;
            stall_left--;
            if (stall_left == 0) begin
               check("stall_cnt", 64'(stall_cnt), 64'd5);
               check("push_during_stall", 64'(blocked_push), 64'd0);
               full = 4'b0000;
            end
         end else if (action == 4'd4) begin
            if (exp_q.size() == 0) begin
               check("extra_push", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("push_word", {30'd0, mindex, din}, {30'd0, e});
            end
            if (!do_stall && pushes > 0) check("push_spacing", 64'(cyc - last_push), 64'd2);
            last_push = cyc;
            pushes++;
         end
         if (frame_done) begin
            check("gap_len", 64'(cyc - last_push), 64'(GAP_CYCLES));
            got_done = 1'b1;
         end
         if (do_stall && !stalled && dbg_state == ST_FRAME_A && pix_addr == 8'd1) begin
            full = 4'b0010;
            stall_left = 5;
            stalled = 1'b1;
         end
      end
      check("frame_done_seen", 64'(got_done), 64'd1);
      check("pushes_per_frame", 64'(pushes), 64'(NUM_CH * NUM_PIX));
      check("missing_push", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      tick();
      check("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
   endtask

   // Directed stimulus and scoreboard
   initial begin
      int extra_push;
      conf_rom[0] = {2'd0, 4'd6, 32'h0000_1111};
      conf_rom[1] = {2'd1, 4'd7, 32'h2222_0001};
      conf_rom[2] = {2'd2, 4'd5, 32'hDEAD_BEEF};
      conf_rom[3] = {2'd3, 4'd2, 32'h1234_5678};
      conf_rom[4] = {2'd0, 4'd3, 32'hCAFE_0000};
      conf_rom[5] = {2'd1, 4'd1, 32'h0000_00FF};
      conf_rom[6] = {2'd2, 4'd9, 32'h8000_0001};

      reset = 1'b1;
      enable = 1'b0;
      full = 4'b0000;
      repeat (3) tick();
      check("rst_action", 64'(action), 64'd0);
      check("rst_din", 64'(din), 64'd0);
      check("rst_loaded", 64'(loaded), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_counts", {32'd0, frame_cnt, stall_cnt}, 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);

      reset = 1'b0;
      for (int i = 0; i < PROG_LEN; i++) begin
         tick();
         check("load_word", {action, mindex, index, din},
               {4'd1, 2'd0, 5'(i), 32'h0000_A000 + 32'(i)});
      end

      for (int j = 0; j < CONF_LEN; j++) begin
         tick();
         check("conf_word", {26'd0, mindex, action, din}, {26'd0, conf_rom[j]});
      end
      tick();
      check("conf_end_action", {mindex, action}, 64'd0);
      check("loaded", 64'(loaded), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      repeat (3) tick();
      check("idle_hold", {busy, action}, 64'd0);

      enable = 1'b1;
      run_frame(1'b0, 1'b0, 1);
      check("no_stall_yet", 64'(stall_cnt), 64'd0);

      run_frame(1'b1, 1'b1, 2);
      check("busy_after_drop", 64'(busy), 64'd0);
      extra_push = 0;
      repeat (20) begin
         tick();
         if (action == 4'd4 || frame_done) extra_push++;
      end
      check("idle_no_push", 64'(extra_push), 64'd0);
      check("idle_frames", 64'(frame_cnt), 64'd2);

      enable = 1'b1;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      check("midrst_outputs", {action, mindex, index, din}, 64'd0);
      check("midrst_flags", {loaded, busy}, 64'd0);
      check("midrst_counts", {32'd0, frame_cnt, stall_cnt}, 64'd0);
      reset = 1'b0;
      enable = 1'b0;
      tick();
      check("reload_0", {action, index, din}, {4'd1, 5'd0, 32'h0000_A000});
      tick();
      check("reload_1", {action, index, din}, {4'd1, 5'd1, 32'h0000_A001});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
